mac_slot_scheduler: RTL and testbench
=====================================

// Module: mac_slot_scheduler
// PURPOSE
//  Shares one byte-serial MAC datapath between NUM_REQ node-evaluation requesters.
//  Picks requesters round-robin and drives the chosen attribute/coefficient words onto the MAC.
//  Holds them stable for the MAC's full accumulation slot, then captures the accumulator.
//  Returns the result to the winner, tagged with its index, on a valid/ready channel.
// PARAMETERS
//  NUM_REQ          4   number of requesters (2..8)
//  ATTR_WIDTH       24  attribute word width
//  RAM1_DATA_WIDTH  34  coefficient word width
//  ACC_WIDTH        20  MAC accumulator width
//  MAC_LATENCY      6   cycles from mac_start to a valid mac_acc
// PORTS
//  clk        in   1                        single clock, rising edge
//  rst_n      in   1                        asynchronous, active-low reset
//  req_valid  in   NUM_REQ                  per-requester operand valid
//  req_ready  out  NUM_REQ                  one-hot grant; transfer when valid&ready
//  req_attr   in   NUM_REQ*ATTR_WIDTH       packed attributes, requester i at slice i
//  req_coeff  in   NUM_REQ*RAM1_DATA_WIDTH  packed coefficients
//  mac_attr   out  ATTR_WIDTH               operand to MAC, registered
//  mac_coeff  out  RAM1_DATA_WIDTH          operand to MAC, registered
//  mac_start  out  1                        1-cycle pulse; clears MAC accumulator/slot counter
//  mac_acc    in   ACC_WIDTH                MAC accumulator result
//  res_valid  out  1                        result valid
//  res_ready  in   1                        result consumer ready
//  res_id     out  $clog2(NUM_REQ)          index of the served requester
//  res_acc    out  ACC_WIDTH                captured accumulator
//  busy       out  1                        high in every state except IDLE
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, rr_ptr=0, cnt=0.
//   All outputs are 0: mac_attr, mac_coeff, mac_start, res_valid, res_id, res_acc, busy.
//  FSM states and transitions:
//   IDLE: req_ready is one-hot for the round-robin winner when any req_valid is high.
//         req_ready is combinational from the registered state and req_valid.
//         On transfer: latch the winner's slices into mac_attr/mac_coeff and the index into res_id.
//         rr_ptr <= winner+1, wrapping to 0 after NUM_REQ-1. Go to LOAD.
//   LOAD: mac_start=1 for exactly this cycle; cnt<=0. Go to RUN.
//   RUN:  cnt increments each cycle.
//         At cnt==MAC_LATENCY-1: res_acc<=mac_acc; go to DONE.
//   DONE: res_valid=1; res_id/res_acc stay stable. Go to IDLE when res_ready=1.
//  Operand stability: mac_attr/mac_coeff change only on an IDLE transfer.
//  Round-robin priority order: rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//  req_ready is 0 in every state except IDLE.
//  Latency: transfer at cycle T -> mac_start at T+1 -> capture at T+1+MAC_LATENCY.
//   res_valid is first high at T+2+MAC_LATENCY.
//   Minimum spacing between grants is MAC_LATENCY+3 cycles.
//  Boundaries:
//   No requests: stays in IDLE; all outputs hold.
//   Requester drops req_valid before its grant: no penalty; arbitration recomputes each cycle.
//   res_ready held high: DONE lasts 1 cycle.
//   res_ready low: DONE is held indefinitely and no new grant is issued (backpressure).
//   Reset mid-slot: immediate abort to IDLE; any partial result is discarded.
//   mac_acc is sampled only at capture; its value at any other time is don't-care.
// CONFIGURATION
//  MAC_SLOT_SCHED_STATS_EN defined:
//   Adds output stat_grants [NUM_REQ*16]: one 16-bit counter per requester.
//   A counter increments on each transfer and saturates at 16'hFFFF.
//   Adds input stat_clr: synchronous clear of all counters; clear wins over a same-cycle increment.
//   Counters reset to 0.
//  Not defined: the stat ports and counters are absent; all other behaviour is identical.
// STRUCTURE
//  Package mac_sched_pkg:
//   state localparams IDLE=0, LOAD=1, RUN=2, DONE=3 (2-bit encoding).
//   CNT_W = $clog2(MAC_LATENCY); STAT_W = 16.
//  Sub-module rr_arbiter #(N):
//   inputs req[N], ptr; outputs gnt[N] (one-hot), gnt_idx.
//   Combinational, with no state of its own.
//   The scheduler owns rr_ptr and advances it on transfer only.
// TESTING
//  1) Reset: only req_valid=4'b0001 -> req_ready=0001; mac_start pulses 1 cycle later.
//     res_valid 8 cycles after the transfer, res_id=0, res_acc = mac_acc sampled at capture.
//  2) Fairness: req_valid=1111 held, res_ready=1 -> grant order 0,1,2,3,0.
//     Each grant is 9 cycles apart.
//  3) Backpressure: res_ready=0 for 20 cycles -> res_valid, res_id, res_acc stable; req_ready=0000.
//     Raise res_ready -> next grant in the following IDLE cycle.
//  4) Reset abort: assert rst_n=0 during RUN at cnt=3 -> all outputs 0 immediately.
//     After release, the next grant starts from requester 0.
//  5) Operand routing: requester 2 attr=24'hA1B2C3, coeff=34'h2_DEAD_BEEF -> mac_attr/mac_coeff show
//     these values from T+1 until the next transfer.
//  6) STATS_EN build: 3 grants to requester 1 -> stat_grants[31:16]=3.
//     stat_clr asserted with a simultaneous grant -> 0. Preload 16'hFFFF -> saturates.

Source files
------------

// File: rtl/mac_sched_pkg.sv
// mac_sched_pkg: shared state encoding and width helpers for the MAC slot scheduler.
package mac_sched_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;
  localparam int STAT_W = 16;
  function automatic int cnt_w(int lat);
    return lat > 2 ? $clog2(lat) : 1;
  endfunction
endpackage

// File: rtl/mac_slot_scheduler_rr_arbiter.sv
// rr_arbiter: stateless round-robin pick, searching from ptr upward modulo N.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx
);
  localparam int IW = $clog2(N);
  logic found;
  logic [IW-1:0] j;
  function automatic int wrap(int a);
    return a >= N ? a - N : a;
  endfunction
  always_comb begin
    gnt = '0;
    gnt_idx = '0;
    found = 1'b0;
    j = '0;
    for (int k = 0; k < N; k++) begin
      j = IW'(wrap(int'(ptr) + k));
      if (!found && req[j]) begin
        found = 1'b1;
        gnt[j] = 1'b1;
        gnt_idx = j;
      end
    end
  end
endmodule

// File: rtl/mac_slot_scheduler.sv
// mac_slot_scheduler: round-robin sharing of one MAC slot; MAC_SLOT_SCHED_STATS_EN adds
// per-requester saturating grant counters (stat_grants) with a synchronous clear (stat_clr).
module mac_slot_scheduler import mac_sched_pkg::*; #(
  parameter int NUM_REQ         = 4,
  parameter int ATTR_WIDTH      = 24,
  parameter int RAM1_DATA_WIDTH = 34,
  parameter int ACC_WIDTH       = 20,
  parameter int MAC_LATENCY     = 6
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ*ATTR_WIDTH-1:0]      req_attr,
  input  logic [NUM_REQ*RAM1_DATA_WIDTH-1:0] req_coeff,
  output logic [ATTR_WIDTH-1:0]              mac_attr,
  output logic [RAM1_DATA_WIDTH-1:0]         mac_coeff,
  output logic                               mac_start,
  input  logic [ACC_WIDTH-1:0]               mac_acc,
  output logic                               res_valid,
  input  logic                               res_ready,
  output logic [$clog2(NUM_REQ)-1:0]         res_id,
  output logic [ACC_WIDTH-1:0]               res_acc,
  output logic                               busy
`ifdef MAC_SLOT_SCHED_STATS_EN
  ,
  output logic [NUM_REQ*STAT_W-1:0]          stat_grants,
  input  logic                               stat_clr
`endif
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CNT_W = cnt_w(MAC_LATENCY);
  state_t state;
  logic [IW-1:0] rr_ptr, gnt_idx;
  logic [NUM_REQ-1:0] gnt;
  logic [CNT_W-1:0] cnt;
  logic xfer;
  rr_arbiter #(.N(NUM_REQ)) u_arb (.req(req_valid), .ptr(rr_ptr), .gnt(gnt), .gnt_idx(gnt_idx));
  assign req_ready = state == IDLE ? gnt : '0;
  assign xfer = |(req_valid & req_ready);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rr_ptr <= '0;
      cnt <= '0;
      mac_attr <= '0;
      mac_coeff <= '0;
      mac_start <= 1'b0;
      res_valid <= 1'b0;
      res_id <= '0;
      res_acc <= '0;
      busy <= 1'b0;
    end else begin
      mac_start <= 1'b0;
      case (state)
        IDLE: if (xfer) begin
          mac_attr <= req_attr[int'(gnt_idx)*ATTR_WIDTH +: ATTR_WIDTH];
          mac_coeff <= req_coeff[int'(gnt_idx)*RAM1_DATA_WIDTH +: RAM1_DATA_WIDTH];
          res_id <= gnt_idx;
          rr_ptr <= gnt_idx == IW'(NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
          mac_start <= 1'b1;
          busy <= 1'b1;
          state <= LOAD;
        end
        LOAD: begin
          cnt <= '0;
          state <= RUN;
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(MAC_LATENCY - 1)) begin
            res_acc <= mac_acc;
            res_valid <= 1'b1;
            state <= DONE;
          end
        end
        DONE: if (res_ready) begin
          res_valid <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
`ifdef MAC_SLOT_SCHED_STATS_EN
  logic [STAT_W-1:0] stat_q [NUM_REQ];
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_stat
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stat_q[i] <= '0;
      else if (stat_clr) stat_q[i] <= '0;
      else if (xfer && gnt[i] && !(&stat_q[i])) stat_q[i] <= stat_q[i] + 1'b1;
    end
    assign stat_grants[i*STAT_W +: STAT_W] = stat_q[i];
  end
`endif
endmodule

// File: tb/tb_mac_slot_scheduler.sv
// tb_mac_slot_scheduler: vector table plus scoreboard of grant/result transactions.
module tb_mac_slot_scheduler;
  localparam int N = 4, AW = 24, CW = 34, ACW = 20, L = 6, IW = 2;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] req_valid, req_ready;
  logic [N*AW-1:0] req_attr;
  logic [N*CW-1:0] req_coeff;
  logic [AW-1:0] mac_attr;
  logic [CW-1:0] mac_coeff;
  logic mac_start, res_valid, res_ready, busy;
  logic [ACW-1:0] mac_acc, res_acc;
  logic [IW-1:0] res_id;
  logic stat_clr;
`ifdef MAC_SLOT_SCHED_STATS_EN
  logic [N*16-1:0] stat_grants;
`endif
  mac_slot_scheduler #(.NUM_REQ(N), .ATTR_WIDTH(AW), .RAM1_DATA_WIDTH(CW), .ACC_WIDTH(ACW),
    .MAC_LATENCY(L)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_attr(req_attr), .req_coeff(req_coeff), .mac_attr(mac_attr), .mac_coeff(mac_coeff),
    .mac_start(mac_start), .mac_acc(mac_acc), .res_valid(res_valid), .res_ready(res_ready),
    .res_id(res_id), .res_acc(res_acc), .busy(busy)
`ifdef MAC_SLOT_SCHED_STATS_EN
    , .stat_grants(stat_grants), .stat_clr(stat_clr)
`endif
  );
  always #5 clk = ~clk;
  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [ACW-1:0] acc_of(int c);
    return ACW'(c * 40503 + 7);
  endfunction
  assign mac_acc = acc_of(cyc);
  int checks = 0, errors = 0;
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask
  function automatic logic [N-1:0] rr_pick(logic [N-1:0] rv, int p);
    for (int k = 0; k < N; k++) if (rv[(p + k) % N]) return N'(1) << ((p + k) % N);
    return '0;
  endfunction
  typedef struct {logic [IW-1:0] id; logic [ACW-1:0] acc; int due;} exp_t;
  exp_t sb[$];
  int glog_id[$], glog_cyc[$];
  int gcount = 0, hscount = 0, glast_id = 0, glast_cyc = 0, hs_cyc = 0, rr_m = 0, mid;
  logic prev_grant = 0, prev_rv = 0, exp_busy = 0, hold = 0;
  logic [IW-1:0] h_id;
  logic [ACW-1:0] h_acc;
  logic [AW-1:0] exp_attr = '0, pend_attr;
  logic [CW-1:0] exp_coeff = '0, pend_coeff;
  logic [N-1:0] mg;
  exp_t e;
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      rr_m = 0;
      prev_grant = 0;
      exp_attr = '0;
      exp_coeff = '0;
      exp_busy = 0;
      hold = 0;
    end else begin
      mg = req_valid & req_ready;
      if (prev_grant) begin
        exp_attr = pend_attr;
        exp_coeff = pend_coeff;
      end
      chk("mac_start", 64'(mac_start), 64'(prev_grant));
      chk("mac_attr", 64'(mac_attr), 64'(exp_attr));
      chk("mac_coeff", 64'(mac_coeff), 64'(exp_coeff));
      chk("busy", 64'(busy), 64'(exp_busy));
      if (exp_busy) chk("ready_when_busy", 64'(req_ready), 64'(0));
      else chk("req_ready", 64'(req_ready), 64'(rr_pick(req_valid, rr_m)));
      if (hold) begin
        chk("hold_valid", 64'(res_valid), 64'(1));
        chk("hold_id", 64'(res_id), 64'(h_id));
        chk("hold_acc", 64'(res_acc), 64'(h_acc));
      end
      if (|mg) begin
        mid = 0;
        for (int k = 0; k < N; k++) if (mg[k]) mid = k;
        e.id = IW'(mid);
        e.acc = acc_of(cyc + 1 + L);
        e.due = cyc + 2 + L;
        sb.push_back(e);
        pend_attr = req_attr[mid*AW +: AW];
        pend_coeff = req_coeff[mid*CW +: CW];
        rr_m = (mid + 1) % N;
        gcount++;
        glast_id = mid;
        glast_cyc = cyc;
        glog_id.push_back(mid);
        glog_cyc.push_back(cyc);
      end
      if (res_valid && !prev_rv) begin
        if (sb.size() == 0) chk("unexpected_result", 64'(1), 64'(0));
        else chk("res_latency", 64'(cyc), 64'(sb[0].due));
      end
      if (res_valid && res_ready && sb.size() != 0) begin
        e = sb.pop_front();
        chk("res_id", 64'(res_id), 64'(e.id));
        chk("res_acc", 64'(res_acc), 64'(e.acc));
        hs_cyc = cyc;
        hscount++;
      end
      hold = res_valid && !res_ready;
      h_id = res_id;
      h_acc = res_acc;
      if (|mg) exp_busy = 1;
      else if (res_valid && res_ready) exp_busy = 0;
      prev_grant = |mg;
    end
    prev_rv = rst_n && res_valid;
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_grant();
    int g0 = gcount;
    for (int i = 0; i < 200 && gcount == g0; i++) step();
    if (gcount == g0) chk("grant_timeout", 64'(0), 64'(1));
  endtask
  task automatic wait_hs();
    int h0 = hscount;
    for (int i = 0; i < 200 && hscount == h0; i++) step();
    if (hscount == h0) chk("result_timeout", 64'(0), 64'(1));
  endtask
  task automatic out_zero(string tag);
    chk({tag, "_attr"}, 64'(mac_attr), 64'(0));
    chk({tag, "_coeff"}, 64'(mac_coeff), 64'(0));
    chk({tag, "_ctl"}, 64'({mac_start, res_valid, busy, res_id, req_ready}), 64'(0));
    chk({tag, "_acc"}, 64'(res_acc), 64'(0));
  endtask
  typedef struct {logic [N-1:0] rv; logic [IW-1:0] id;} vec_t;
  vec_t tv[8];
  initial begin
    tv[0] = '{4'b0001, 2'd0};
    tv[1] = '{4'b1111, 2'd1};
    tv[2] = '{4'b0011, 2'd0};
    tv[3] = '{4'b1010, 2'd1};
    tv[4] = '{4'b1010, 2'd3};
    tv[5] = '{4'b0100, 2'd2};
    tv[6] = '{4'b1001, 2'd3};
    tv[7] = '{4'b1001, 2'd0};
    req_valid = '0;
    res_ready = 1'b1;
    stat_clr = 1'b0;
    req_attr = {24'h3C3C3C, 24'hA1B2C3, 24'h5A5A5A, 24'h123456};
    req_coeff = {34'h1_1111_2222, 34'h2_DEAD_BEEF, 34'h0_CAFE_F00D, 34'h3_0000_0001};
    step();
    out_zero("reset");
    step();
    rst_n = 1'b1;
    repeat (4) step();
    for (int i = 0; i < 8; i++) begin
      req_valid = tv[i].rv;
      wait_grant();
      chk("table_id", 64'(glast_id), 64'(tv[i].id));
      if (tv[i].id == 2) begin
        chk("route_attr", 64'(mac_attr), 64'(24'hA1B2C3));
        chk("route_coeff", 64'(mac_coeff), 64'(34'h2_DEAD_BEEF));
      end
      req_valid = '0;
      wait_hs();
    end
    repeat (5) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    glog_id.delete();
    glog_cyc.delete();
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) wait_grant();
    req_valid = '0;
    wait_hs();
    chk("fair_count", 64'(glog_id.size()), 64'(5));
    for (int i = 0; i < 5 && i < glog_id.size(); i++) begin
      chk("fair_order", 64'(glog_id[i]), 64'(i % N));
      if (i > 0) chk("fair_spacing", 64'(glog_cyc[i] - glog_cyc[i-1]), 64'(L + 3));
    end
    res_ready = 1'b0;
    req_valid = 4'b0010;
    wait_grant();
    chk("bp_id", 64'(glast_id), 64'(1));
    req_valid = 4'b1111;
    for (int i = 0; i < 20 && !res_valid; i++) step();
    chk("bp_valid", 64'(res_valid), 64'(1));
    repeat (20) step();
    chk("bp_ready", 64'(req_ready), 64'(0));
    res_ready = 1'b1;
    wait_grant();
    chk("bp_regrant", 64'(glast_cyc - hs_cyc), 64'(1));
    chk("bp_regrant_id", 64'(glast_id), 64'(2));
    req_valid = '0;
    wait_hs();
    req_valid = 4'b1000;
    wait_grant();
    req_valid = '0;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    out_zero("abort");
    step();
    rst_n = 1'b1;
    req_valid = 4'b1111;
    wait_grant();
    chk("abort_regrant_id", 64'(glast_id), 64'(0));
    req_valid = '0;
    wait_hs();
`ifdef MAC_SLOT_SCHED_STATS_EN
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("stat_reset", 64'(stat_grants), 64'(0));
    for (int i = 0; i < 3; i++) begin
      req_valid = 4'b0010;
      wait_grant();
      req_valid = '0;
      wait_hs();
    end
    chk("stat_three", 64'(stat_grants[31:16]), 64'(3));
    begin
      int g0 = gcount;
      req_valid = 4'b0010;
      stat_clr = 1'b1;
      step();
      stat_clr = 1'b0;
      req_valid = '0;
      chk("stat_clr_grant", 64'(gcount - g0), 64'(1));
      chk("stat_clr_wins", 64'(stat_grants[31:16]), 64'(0));
      wait_hs();
    end
`endif
    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
